// File: rtl/multi_block_controller.sv
// Multi-block sprite controller: N_BLK movable rectangles, one selected at a time.
// Positions/background/selection update on clk edges (moves gated by tick); rgb is combinational.
// No flow control: inputs are sampled every cycle, outputs are always valid.
module multi_block_controller #(
  parameter int N_BLK  = 4,
  parameter int STEP   = 2,
  parameter int HALF_W = 5,
  parameter int HALF_H = 10,
  parameter int X_MIN  = 144,
  parameter int X_MAX  = 783,
  parameter int Y_MIN  = 35,
  parameter int Y_MAX  = 514
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       bright,
  input  logic                       up,
  input  logic                       down,
  input  logic                       left,
  input  logic                       right,
  input  logic                       sel,
  input  logic [9:0]                 hCount,
  input  logic [9:0]                 vCount,
  output logic [11:0]                rgb,
  output logic [11:0]                background,
  output logic [$clog2(N_BLK)-1:0]   active_idx
);

  localparam int IW = $clog2(N_BLK);

  // 11-bit constants so wrap comparisons never underflow or overflow.
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] HW_W    = 11'(HALF_W);
  localparam logic [10:0] HH_W    = 11'(HALF_H);
  localparam logic [10:0] XMIN_W  = 11'(X_MIN);
  localparam logic [10:0] XMAX_W  = 11'(X_MAX);
  localparam logic [10:0] YMIN_W  = 11'(Y_MIN);
  localparam logic [10:0] YMAX_W  = 11'(Y_MAX);

  logic [9:0]       x [N_BLK];
  logic [9:0]       y [N_BLK];
  logic             sel_q;
  logic             sel_rise;
  logic [10:0]      cur_x;
  logic [10:0]      cur_y;
  logic [10:0]      nxt_x;
  logic [10:0]      nxt_y;
  logic [N_BLK-1:0] hit;

  assign sel_rise = sel & ~sel_q;
  assign cur_x    = {1'b0, x[active_idx]};
  assign cur_y    = {1'b0, y[active_idx]};

  // Next position of the selected block: right > left > up > down, one axis only.
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (right) begin
      nxt_x = (cur_x + STEP_W > XMAX_W) ? XMIN_W : cur_x + STEP_W;
    end else if (left) begin
      nxt_x = (cur_x < XMIN_W + STEP_W) ? XMAX_W : cur_x - STEP_W;
    end else if (up) begin
      nxt_y = (cur_y < YMIN_W + STEP_W) ? YMAX_W : cur_y - STEP_W;
    end else if (down) begin
      nxt_y = (cur_y + STEP_W > YMAX_W) ? YMIN_W : cur_y + STEP_W;
    end
  end

  // Block positions: only the (pre-increment) selected block moves, and only on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BLK; i++) begin
        x[i] <= 10'(X_MIN + 16 + 32 * i);
        y[i] <= 10'(Y_MIN + 16);
      end
    end else begin
      for (int i = 0; i < N_BLK; i++) begin
        if (tick && active_idx == IW'(i)) begin
          x[i] <= nxt_x[9:0];
          y[i] <= nxt_y[9:0];
        end
      end
    end
  end

  // Selection: one increment per sel rising edge, wrapping at N_BLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q      <= 1'b0;
      active_idx <= '0;
    end else begin
      sel_q <= sel;
      if (sel_rise) begin
        if (active_idx == IW'(N_BLK - 1)) active_idx <= '0;
        else                              active_idx <= active_idx + IW'(1);
      end
    end
  end

  // Background colour tracks the last button seen on a tick: right > left > down > up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      background <= 12'hFFF;
    end else if (tick) begin
      if (right)      background <= 12'hFF0;
      else if (left)  background <= 12'h0FF;
      else if (down)  background <= 12'h0F0;
      else if (up)    background <= 12'h00F;
    end
  end

  // Per-block hit test, written as two one-sided compares to stay unsigned-safe.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_BLK; i++) begin
      hit[i] = ({1'b0, hCount} + HW_W >= {1'b0, x[i]}) &&
               ({1'b0, hCount} <= {1'b0, x[i]} + HW_W) &&
               ({1'b0, vCount} + HH_W >= {1'b0, y[i]}) &&
               ({1'b0, vCount} <= {1'b0, y[i]} + HH_W);
    end
  end

  // Pixel colour: blanking first, then the lowest-index hit block, else white.
  always_comb begin
    logic found;
    found = 1'b0;
    rgb   = 12'hFFF;
    if (!bright) begin
      rgb = 12'h000;
    end else begin
      for (int i = 0; i < N_BLK; i++) begin
        if (hit[i] && !found) begin
          found = 1'b1;
          if (active_idx == IW'(i)) rgb = 12'hFF0;
          else if ((i % 2) == 0)    rgb = 12'hF00;
          else                      rgb = 12'h0F0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_block_controller.sv
// Self-checking bench for multi_block_controller.
// Positions are observed through the raster output by probing around each block.
// A spec-level model (integer arrays, abs() distances) predicts every output.
module tb_multi_block_controller;

  localparam int N      = 4;
  localparam int STEP   = 2;
  localparam int HW     = 5;
  localparam int HH     = 10;
  localparam int XMIN   = 144;
  localparam int XMAX   = 783;
  localparam int YMIN   = 35;
  localparam int YMAX   = 514;
  localparam int IW     = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0, bright = 1'b1;
  logic          up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, sel = 1'b0;
  logic [9:0]    hCount = '0, vCount = '0;
  logic [11:0]   rgb, background;
  logic [IW-1:0] active_idx;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int mx [N];
  int my [N];
  int midx;
  int mbg;
  bit msel_q;

  multi_block_controller #(
    .N_BLK(N), .STEP(STEP), .HALF_W(HW), .HALF_H(HH),
    .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .bright(bright),
    .up(up), .down(down), .left(left), .right(right), .sel(sel),
    .hCount(hCount), .vCount(vCount),
    .rgb(rgb), .background(background), .active_idx(active_idx)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = XMIN + 16 + 32 * i;
      my[i] = YMIN + 16;
    end
    midx   = 0;
    mbg    = 'hFFF;
    msel_q = 0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs currently driven.
  function automatic void model_step();
    if (tick) begin
      if (right)     mx[midx] = (mx[midx] + STEP > XMAX) ? XMIN : mx[midx] + STEP;
      else if (left) mx[midx] = (mx[midx] < XMIN + STEP) ? XMAX : mx[midx] - STEP;
      else if (up)   my[midx] = (my[midx] < YMIN + STEP) ? YMAX : my[midx] - STEP;
      else if (down) my[midx] = (my[midx] + STEP > YMAX) ? YMIN : my[midx] + STEP;
      if (right)     mbg = 'hFF0;
      else if (left) mbg = 'h0FF;
      else if (down) mbg = 'h0F0;
      else if (up)   mbg = 'h00F;
    end
    if (sel && !msel_q) midx = (midx + 1) % N;
    msel_q = sel;
  endfunction

  function automatic logic [11:0] model_rgb(input int h, input int v);
    if (!bright) return 12'h000;
    for (int i = 0; i < N; i++) begin
      if (iabs(h - mx[i]) <= HW && iabs(v - my[i]) <= HH) begin
        if (i == midx)   return 12'hFF0;
        if (i % 2 == 0)  return 12'hF00;
        return 12'h0F0;
      end
    end
    return 12'hFFF;
  endfunction

  // Advance one clock, keeping the model in lock-step; outputs settle 1 time unit after.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input bit t, input bit r, input bit l, input bit u, input bit d);
    tick = t; right = r; left = l; up = u; down = d;
  endtask

  // Place the raster on block b at one of 7 positions: centre, corners, just outside.
  task automatic probe(input int b, input int k);
    int dx, dy;
    case (k)
      0: begin dx = 0;       dy = 0;       end
      1: begin dx = HW;      dy = HH;      end
      2: begin dx = -HW;     dy = -HH;     end
      3: begin dx = HW + 1;  dy = 0;       end
      4: begin dx = -HW - 1; dy = 0;       end
      5: begin dx = 0;       dy = HH + 1;  end
      default: begin dx = 0; dy = -HH - 1; end
    endcase
    hCount = 10'(mx[b] + dx);
    vCount = 10'(my[b] + dy);
    #1;
  endtask

  task automatic do_reset();
    set_buttons(0, 0, 0, 0, 0);
    sel = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (active_idx !== '0) begin
      fails++; $display("FAIL reset_idx got=%0d want=0", active_idx);
    end
    tests++;
    if (background !== 12'hFFF) begin
      fails++; $display("FAIL reset_bg got=%h want=fff", background);
    end
    bright = 1'b1;
    hCount = 10'd160; vCount = 10'd51; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL reset_rgb_blk0 got=%h want=ff0", rgb);
    end
    hCount = 10'd192; #1;
    tests++;
    if (rgb !== 12'h0F0) begin
      fails++; $display("FAIL reset_rgb_blk1 got=%h want=0f0", rgb);
    end
    hCount = 10'd170; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL reset_rgb_gap got=%h want=fff", rgb);
    end
    bright = 1'b0; hCount = 10'd160; #1;
    tests++;
    if (rgb !== 12'h000) begin
      fails++; $display("FAIL reset_rgb_dark got=%h want=000", rgb);
    end
    bright = 1'b1;
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < 7; k++) begin
        probe(b, k);
        tests++;
        if (rgb !== model_rgb(hCount, vCount)) begin
          fails++;
          $display("FAIL reset_probe b=%0d k=%0d h=%0d v=%0d got=%h want=%h",
                   b, k, hCount, vCount, rgb, model_rgb(hCount, vCount));
        end
      end
    end
  endtask

  task automatic test_right();
    set_buttons(1, 1, 0, 0, 0);
    repeat (3) step();
    set_buttons(0, 0, 0, 0, 0);
    tests++;
    if (background !== 12'hFF0) begin
      fails++; $display("FAIL right_bg got=%h want=ff0", background);
    end
    // block 0 now centred at x=166 -> spans 161..171
    vCount = 10'd51;
    hCount = 10'd160; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL right_left_edge got=%h want=fff", rgb);
    end
    hCount = 10'd161; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL right_in_edge got=%h want=ff0", rgb);
    end
    hCount = 10'd172; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL right_right_edge got=%h want=fff", rgb);
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 7; k++) begin
        probe(b, k);
        tests++;
        if (rgb !== model_rgb(hCount, vCount)) begin
          fails++;
          $display("FAIL right_probe b=%0d k=%0d got=%h want=%h", b, k, rgb, model_rgb(hCount, vCount));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    set_buttons(1, 1, 0, 0, 0);
    while (mx[0] != 782 && guard < 1000) begin step(); guard++; end
    step();  // 782 + 2 > 783 -> wraps to X_MIN
    set_buttons(0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      probe(0, k);
      tests++;
      if (rgb !== model_rgb(hCount, vCount)) begin
        fails++;
        $display("FAIL wrap_right k=%0d h=%0d got=%h want=%h", k, hCount, rgb, model_rgb(hCount, vCount));
      end
    end
    hCount = 10'd144; vCount = 10'd51; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL wrap_right_xmin got=%h want=ff0", rgb);
    end
    guard = 0;
    set_buttons(1, 0, 1, 0, 0);
    while (mx[0] != 145 && guard < 1000) begin step(); guard++; end
    step();  // 145 < 146 -> wraps to X_MAX
    set_buttons(0, 0, 0, 0, 0);
    hCount = 10'd783; vCount = 10'd51; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL wrap_left_xmax got=%h want=ff0", rgb);
    end
    hCount = 10'd777; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL wrap_left_outside got=%h want=fff", rgb);
    end
    tests++;
    if (background !== 12'h0FF) begin
      fails++; $display("FAIL wrap_left_bg got=%h want=0ff", background);
    end
  endtask

  task automatic test_sel();
    do_reset();
    sel = 1'b1;
    repeat (5) step();
    tests++;
    if (active_idx !== IW'(1)) begin
      fails++; $display("FAIL sel_hold got=%0d want=1", active_idx);
    end
    sel = 1'b0; step();
    repeat (4) begin
      sel = 1'b1; step();
      sel = 1'b0; step();
    end
    tests++;
    if (active_idx !== IW'(midx) || active_idx !== IW'(1)) begin
      fails++; $display("FAIL sel_wrap got=%0d want=1", active_idx);
    end
  endtask

  task automatic test_sel_tick();
    do_reset();
    set_buttons(1, 0, 0, 1, 0);
    sel = 1'b1;
    step();
    set_buttons(0, 0, 0, 0, 0);
    sel = 1'b0;
    tests++;
    if (active_idx !== IW'(1)) begin
      fails++; $display("FAIL seltick_idx got=%0d want=1", active_idx);
    end
    // block 0 at y=49, now unselected: spans rows 39..59
    hCount = 10'd160; vCount = 10'd59; #1;
    tests++;
    if (rgb !== 12'hF00) begin
      fails++; $display("FAIL seltick_blk0_bottom got=%h want=f00", rgb);
    end
    vCount = 10'd60; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL seltick_blk0_below got=%h want=fff", rgb);
    end
    hCount = 10'd192; vCount = 10'd61; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL seltick_blk1_bottom got=%h want=ff0", rgb);
    end
  endtask

  task automatic test_reset_mid();
    set_buttons(1, 1, 0, 0, 0);
    repeat (4) step();
    rst = 1'b1;  // asserted away from any edge; must take effect immediately
    #1;
    tests++;
    if (active_idx !== '0 || background !== 12'hFFF) begin
      fails++; $display("FAIL midrst_async idx=%0d bg=%h want=0/fff", active_idx, background);
    end
    hCount = 10'd160; vCount = 10'd51; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL midrst_pos got=%h want=ff0", rgb);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step();  // first tick after reset: 160 -> 162
    set_buttons(0, 0, 0, 0, 0);
    hCount = 10'd167; #1;
    tests++;
    if (rgb !== 12'hFF0) begin
      fails++; $display("FAIL midrst_first_tick got=%h want=ff0", rgb);
    end
    hCount = 10'd156; #1;
    tests++;
    if (rgb !== 12'hFFF) begin
      fails++; $display("FAIL midrst_first_tick_edge got=%h want=fff", rgb);
    end
  endtask

  task automatic test_random();
    int b, k;
    for (int c = 0; c < 1500; c++) begin
      tick   = ($urandom_range(0, 2) == 0);
      right  = ($urandom_range(0, 3) == 0);
      left   = ($urandom_range(0, 3) == 0);
      up     = ($urandom_range(0, 3) == 0);
      down   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      bright = ($urandom_range(0, 9) != 0);
      step();
      b = $urandom_range(0, N - 1);
      k = $urandom_range(0, 6);
      probe(b, k);
      tests++;
      if (rgb !== model_rgb(hCount, vCount) || background !== 12'(mbg) ||
          active_idx !== IW'(midx)) begin
        fails++;
        $display("FAIL random c=%0d h=%0d v=%0d rgb=%h/%h bg=%h/%h idx=%0d/%0d",
                 c, hCount, vCount, rgb, model_rgb(hCount, vCount),
                 background, 12'(mbg), active_idx, midx);
      end
    end
    set_buttons(0, 0, 0, 0, 0);
    sel = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_right();
    test_wrap();
    test_sel();
    test_sel_tick();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
